// File: rtl/conv_enc_stream.sv
// Streaming convolutional encoder with runtime K (3..9) and rate 1/2 or 1/3.
// Valid/ready on info bits and code symbols, with zero-tail trellis termination.
module conv_enc_stream #(
    parameter int unsigned MAX_K = 9,
    parameter int unsigned MAX_N = 3,
    parameter int unsigned LEN_W = 12
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic [1:0]               i_constr_len,
    input  logic                     i_code_rate,
    input  logic [MAX_N*MAX_K-1:0]   i_gen_poly,
    input  logic [LEN_W-1:0]         i_frame_len,
    input  logic                     i_tail_en,
    input  logic                     i_bit,
    input  logic                     i_bit_valid,
    output logic                     o_bit_ready,
    output logic [MAX_N-1:0]         o_sym,
    output logic                     o_sym_valid,
    input  logic                     i_sym_ready,
    output logic                     o_sym_last,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_cfg_err
);

    localparam int unsigned KW = 4;

    typedef enum logic [1:0] {StIdle, StData, StTail, StFlush} state_e;

    state_e                   state_q, state_d;
    logic [KW-1:0]            k_q, k_d;
    logic                     rate_q, rate_d;
    logic [MAX_N*MAX_K-1:0]   poly_q, poly_d;
    logic [LEN_W-1:0]         len_q, len_d;
    logic                     tail_q, tail_d;
    logic [MAX_K-2:0]         sr_q, sr_d;
    logic [LEN_W-1:0]         cnt_q, cnt_d;
    logic [KW-1:0]            tcnt_q, tcnt_d;
    logic [MAX_N-1:0]         sym_q, sym_d;
    logic                     sym_valid_q, sym_valid_d;
    logic                     sym_last_q, sym_last_d;
    logic                     done_q, done_d;
    logic                     cfg_err_q, cfg_err_d;

    logic                     slot_free;
    logic                     bit_ready;
    logic                     bit_fire;
    logic                     tail_fire;
    logic                     enc_in;
    logic                     last_bit;
    logic                     last_tail;
    logic [LEN_W:0]           cnt_inc;
    logic [MAX_K-1:0]         win;
    logic [MAX_K-1:0]         k_mask;
    logic [MAX_N-1:0]         enc_sym;

    assign slot_free = !sym_valid_q || i_sym_ready;
    assign bit_ready = (state_q == StData) && slot_free;
    assign bit_fire  = bit_ready && i_bit_valid;
    assign tail_fire = (state_q == StTail) && slot_free;
    assign enc_in    = (state_q == StData) ? i_bit : 1'b0;
    assign cnt_inc   = {1'b0, cnt_q} + (LEN_W + 1)'(1);
    assign last_bit  = cnt_inc == {1'b0, len_q};
    assign last_tail = (tcnt_q + KW'(1)) == (k_q - KW'(1));

    // Newest history bit sits at the top of sr_q, so the K-wide window is the
    // top K bits of {input, history}.
    assign win = {enc_in, sr_q} >> (MAX_K - 32'(k_q));

    always_comb begin
        k_mask  = '0;
        enc_sym = '0;
        for (int i = 0; i < int'(MAX_K); i++) begin
            k_mask[i] = i < int'(k_q);
        end
        for (int j = 0; j < int'(MAX_N); j++) begin
            if (j < 2 || rate_q) begin
                enc_sym[j] = ^(poly_q[j*MAX_K +: MAX_K] & k_mask & win);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        rate_d      = rate_q;
        poly_d      = poly_q;
        len_d       = len_q;
        tail_d      = tail_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        tcnt_d      = tcnt_q;
        sym_d       = sym_q;
        sym_valid_d = sym_valid_q;
        sym_last_d  = sym_last_q;
        done_d      = 1'b0;
        cfg_err_d   = i_start && (state_q != StIdle);

        if (slot_free) begin
            sym_d       = '0;
            sym_valid_d = 1'b0;
            sym_last_d  = 1'b0;
        end
        if (bit_fire || tail_fire) begin
            sym_d       = enc_sym;
            sym_valid_d = 1'b1;
            sym_last_d  = bit_fire ? (last_bit && !tail_q) : last_tail;
            sr_d        = {enc_in, sr_q[MAX_K-2:1]};
        end

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    k_d    = KW'(3) + {1'b0, i_constr_len, 1'b0};
                    rate_d = i_code_rate;
                    poly_d = i_gen_poly;
                    len_d  = i_frame_len;
                    tail_d = i_tail_en;
                    sr_d   = '0;
                    cnt_d  = '0;
                    tcnt_d = '0;
                    if (i_frame_len != '0) begin
                        state_d = StData;
                    end else begin
                        state_d = i_tail_en ? StTail : StFlush;
                    end
                end
            end
            StData: begin
                if (bit_fire) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (last_bit) begin
                        state_d = tail_q ? StTail : StFlush;
                    end
                end
            end
            StTail: begin
                if (tail_fire) begin
                    tcnt_d = tcnt_q + KW'(1);
                    if (last_tail) begin
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                // Slot free here means the final symbol (if any) has been taken.
                if (slot_free) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            k_q         <= '0;
            rate_q      <= 1'b0;
            poly_q      <= '0;
            len_q       <= '0;
            tail_q      <= 1'b0;
            sr_q        <= '0;
            cnt_q       <= '0;
            tcnt_q      <= '0;
            sym_q       <= '0;
            sym_valid_q <= 1'b0;
            sym_last_q  <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            rate_q      <= rate_d;
            poly_q      <= poly_d;
            len_q       <= len_d;
            tail_q      <= tail_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            tcnt_q      <= tcnt_d;
            sym_q       <= sym_d;
            sym_valid_q <= sym_valid_d;
            sym_last_q  <= sym_last_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign o_bit_ready = bit_ready;
    assign o_sym       = sym_q;
    assign o_sym_valid = sym_valid_q;
    assign o_sym_last  = sym_last_q;
    assign o_busy      = state_q != StIdle;
    assign o_done      = done_q;
    assign o_cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_conv_enc_stream.sv
// Directed bench for conv_enc_stream: expected symbols are queued per frame
// and popped by a monitor at each output handshake.
module tb_conv_enc_stream;

    localparam int unsigned MAX_K = 9;
    localparam int unsigned MAX_N = 3;
    localparam int unsigned LEN_W = 12;

    logic                   sys_clk;
    logic                   rst;
    logic                   i_start;
    logic [1:0]             i_constr_len;
    logic                   i_code_rate;
    logic [MAX_N*MAX_K-1:0] i_gen_poly;
    logic [LEN_W-1:0]       i_frame_len;
    logic                   i_tail_en;
    logic                   i_bit;
    logic                   i_bit_valid;
    logic                   o_bit_ready;
    logic [MAX_N-1:0]       o_sym;
    logic                   o_sym_valid;
    logic                   i_sym_ready;
    logic                   o_sym_last;
    logic                   o_busy;
    logic                   o_done;
    logic                   o_cfg_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int last_cyc = -100;
    logic [3:0] sb[$];
    logic [3:0] mon_exp;

    // g0=111, g1=101, g2=011
    localparam logic [26:0] Poly3 = {9'h003, 9'h005, 9'h007};

    conv_enc_stream #(
        .MAX_K(MAX_K),
        .MAX_N(MAX_N),
        .LEN_W(LEN_W)
    ) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_constr_len(i_constr_len),
        .i_code_rate (i_code_rate),
        .i_gen_poly  (i_gen_poly),
        .i_frame_len (i_frame_len),
        .i_tail_en   (i_tail_en),
        .i_bit       (i_bit),
        .i_bit_valid (i_bit_valid),
        .o_bit_ready (o_bit_ready),
        .o_sym       (o_sym),
        .o_sym_valid (o_sym_valid),
        .i_sym_ready (i_sym_ready),
        .o_sym_last  (o_sym_last),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_cfg_err   (o_cfg_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: a handshake completes at the next rising edge.
    always @(negedge sys_clk) begin
        if (rst && o_sym_valid && i_sym_ready) begin
            hs_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_sym", 32'(o_sym_valid), 32'd0);
            end else begin
                mon_exp = sb.pop_front();
                check("sym", 32'({o_sym_last, o_sym}), 32'(mon_exp));
                if (mon_exp[3]) last_cyc = cyc;
            end
        end
    end

    task automatic push_model(input int k, input logic rate, input logic [26:0] poly,
                              input int n, input logic [15:0] bits, input logic tail);
        int total;
        logic [31:0] seq;
        logic [2:0] sym;
        logic acc;
        total = n + (tail ? k - 1 : 0);
        seq = '0;
        for (int t = 0; t < n; t++) seq[t] = bits[t];
        for (int t = 0; t < total; t++) begin
            sym = '0;
            for (int j = 0; j < 3; j++) begin
                if (j < 2 || rate) begin
                    acc = 1'b0;
                    for (int i = 0; i < k; i++) begin
                        if (t - (k - 1 - i) >= 0) acc ^= poly[j*9 + i] & seq[t - (k - 1 - i)];
                    end
                    sym[j] = acc;
                end
            end
            sb.push_back({(t == total - 1), sym});
        end
    endtask

    task automatic push_t1();
        sb.push_back(4'b0011);
        sb.push_back(4'b0001);
        sb.push_back(4'b0000);
        sb.push_back(4'b0010);
        sb.push_back(4'b0010);
        sb.push_back(4'b1011);
    endtask

    task automatic pulse_start(input logic [1:0] ksel, input logic rate, input logic [26:0] poly,
                               input logic [11:0] len, input logic tail);
        @(posedge sys_clk); #1;
        i_constr_len = ksel;
        i_code_rate  = rate;
        i_gen_poly   = poly;
        i_frame_len  = len;
        i_tail_en    = tail;
        i_start      = 1'b1;
        @(posedge sys_clk); #1;
        i_start      = 1'b0;
    endtask

    task automatic send_bits(input int n, input logic [15:0] bits);
        logic acc;
        int g;
        for (int i = 0; i < n; i++) begin
            i_bit       = bits[i];
            i_bit_valid = 1'b1;
            acc = 1'b0;
            g = 0;
            while (!acc && g < 200) begin
                @(negedge sys_clk);
                acc = o_bit_ready;
                @(posedge sys_clk); #1;
                g++;
            end
            if (!acc) check("bit_accept_timeout", 32'(acc), 32'd1);
        end
        i_bit_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int dcyc);
        int n;
        logic found;
        found = 1'b0;
        n = 0;
        dcyc = -1;
        while (!found && n < limit) begin
            @(negedge sys_clk);
            if (o_done) begin
                found = 1'b1;
                dcyc = cyc;
            end
            n++;
        end
        check("done_seen", 32'(found), 32'd1);
    endtask

    task automatic sync_hs(input int target);
        int g;
        g = 0;
        while (hs_cnt != target && g < 100) begin
            @(negedge sys_clk); #1;
            g++;
        end
        if (hs_cnt != target) check("hs_sync", 32'(hs_cnt), 32'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        int base;
        logic [26:0] rpoly;
        logic [15:0] rbits;

        rst = 1'b0;
        i_start = 1'b0; i_constr_len = '0; i_code_rate = 1'b0; i_gen_poly = '0;
        i_frame_len = '0; i_tail_en = 1'b0; i_bit = 1'b0; i_bit_valid = 1'b0;
        i_sym_ready = 1'b1;
        #1;
        check("reset_outputs", 32'({o_sym, o_sym_valid, o_sym_last, o_busy, o_done,
                                    o_cfg_err, o_bit_ready}), 32'd0);
        repeat (2) @(posedge sys_clk);
        #1 rst = 1'b1;

        // Rate 1/2, K=3, bits 1,0,1,1 with tail
        push_t1();
        pulse_start(2'd0, 1'b0, Poly3, 12'd4, 1'b1);
        check("busy_set", 32'(o_busy), 32'd1);
        send_bits(4, 16'b1101);
        wait_done(50, dc);
        check("done_latency", 32'(dc - last_cyc), 32'd1);
        check("busy_drop", 32'(o_busy), 32'd0);
        check("sb_empty_t1", 32'(sb.size()), 32'd0);

        // Same frame with a 5-cycle stall on the second symbol
        push_t1();
        base = hs_cnt;
        pulse_start(2'd0, 1'b0, Poly3, 12'd4, 1'b1);
        fork
            send_bits(4, 16'b1101);
            begin
                sync_hs(base + 1);
                @(posedge sys_clk); #1 i_sym_ready = 1'b0;
                repeat (5) begin
                    @(negedge sys_clk);
                    check("stall_sym", 32'(o_sym), 32'b001);
                    check("stall_valid", 32'(o_sym_valid), 32'd1);
                    check("stall_bit_ready", 32'(o_bit_ready), 32'd0);
                end
                @(posedge sys_clk); #1 i_sym_ready = 1'b1;
            end
        join
        wait_done(50, dc);
        check("stall_count", 32'(hs_cnt - base), 32'd6);
        check("sb_empty_stall", 32'(sb.size()), 32'd0);

        // Rate 1/3, single bit, no tail
        sb.push_back(4'b1011);
        pulse_start(2'd0, 1'b1, Poly3, 12'd1, 1'b0);
        send_bits(1, 16'b1);
        wait_done(20, dc);
        check("done_latency_r3", 32'(dc - last_cyc), 32'd1);
        check("sb_empty_r3", 32'(sb.size()), 32'd0);

        // Empty frame: no symbols, done within 2 cycles
        base = hs_cnt;
        pulse_start(2'd0, 1'b0, Poly3, 12'd0, 1'b0);
        wait_done(2, dc);
        check("empty_no_sym", 32'(hs_cnt - base), 32'd0);

        // Start while busy: cfg_err pulse, frame unaffected
        push_t1();
        base = hs_cnt;
        pulse_start(2'd0, 1'b0, Poly3, 12'd4, 1'b1);
        fork
            send_bits(4, 16'b1101);
            begin
                sync_hs(base + 2);
                @(posedge sys_clk); #1;
                i_start = 1'b1; i_constr_len = 2'd3; i_code_rate = 1'b1; i_frame_len = 12'd9;
                @(posedge sys_clk); #1 i_start = 1'b0;
                @(negedge sys_clk);
                check("cfg_err", 32'(o_cfg_err), 32'd1);
                check("busy_keep", 32'(o_busy), 32'd1);
                @(negedge sys_clk);
                check("cfg_err_pulse", 32'(o_cfg_err), 32'd0);
            end
        join
        wait_done(50, dc);
        check("sb_empty_cfg", 32'(sb.size()), 32'd0);

        // K=9, rate 1/3, random bits and polys, random backpressure
        rpoly = 27'($urandom);
        rbits = 16'($urandom_range(0, 255));
        push_model(9, 1'b1, rpoly, 8, rbits, 1'b1);
        base = hs_cnt;
        pulse_start(2'd3, 1'b1, rpoly, 12'd8, 1'b1);
        fork
            send_bits(8, rbits);
            begin
                repeat (12) begin
                    @(posedge sys_clk); #1 i_sym_ready = 1'($urandom_range(0, 1));
                end
                @(posedge sys_clk); #1 i_sym_ready = 1'b1;
            end
        join
        wait_done(100, dc);
        check("k9_count", 32'(hs_cnt - base), 32'd16);
        check("done_latency_k9", 32'(dc - last_cyc), 32'd1);
        check("sb_empty_k9", 32'(sb.size()), 32'd0);

        // K=5, rate 1/2, no tail
        rpoly = 27'($urandom);
        rbits = 16'($urandom_range(0, 63));
        push_model(5, 1'b0, rpoly, 6, rbits, 1'b0);
        pulse_start(2'd1, 1'b0, rpoly, 12'd6, 1'b0);
        send_bits(6, rbits);
        wait_done(50, dc);
        check("sb_empty_k5", 32'(sb.size()), 32'd0);

        // Reset after the third symbol, then re-encode from a clean history
        push_model(3, 1'b0, Poly3, 8, 16'h00ff, 1'b1);
        base = hs_cnt;
        pulse_start(2'd0, 1'b0, Poly3, 12'd8, 1'b1);
        i_bit = 1'b1;
        i_bit_valid = 1'b1;
        sync_hs(base + 3);
        #2 rst = 1'b0;
        #1;
        check("abort_outputs", 32'({o_sym, o_sym_valid, o_sym_last, o_busy, o_done,
                                    o_cfg_err, o_bit_ready}), 32'd0);
        sb.delete();
        i_bit_valid = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1 rst = 1'b1;
        push_t1();
        pulse_start(2'd0, 1'b0, Poly3, 12'd4, 1'b1);
        send_bits(4, 16'b1101);
        wait_done(50, dc);
        check("sb_empty_post_rst", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_enc_stream.md
Name: conv_enc_stream

Overview:
- Parametrised streaming convolutional encoder for the endec datapath; successor to the fixed-rate, control-sequenced encoder.
- Runtime-selectable constraint length (up to MAX_K) and code rate 1/2 or 1/3.
- Per-frame configuration latched at start; zero-tail trellis termination.
- Valid/ready handshakes on input bits and output symbols, so it can feed the decoder bench or an external channel model without the global enable sequencer.

Parameters:
- MAX_K, 9, maximum constraint length; shift register holds MAX_K-1 bits.
- MAX_N, 3, maximum code outputs per symbol (rate 1/MAX_N).
- LEN_W, 12, width of frame-length field; frames are up to 2^LEN_W-1 info bits.

Ports:
- sys_clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle pulse; latches config and begins a frame.
- i_constr_len  in  2  K select: 0→K=3, 1→K=5, 2→K=7, 3→K=9. Must satisfy K≤MAX_K.
- i_code_rate  in  1  0 = rate 1/2, 1 = rate 1/3.
- i_gen_poly  in  MAX_N*MAX_K  generator j in bits [j*MAX_K +: MAX_K].
- i_frame_len  in  LEN_W  info bits in the frame.
- i_tail_en  in  1  1 = append K-1 zero tail bits.
- i_bit  in  1  info bit.
- i_bit_valid  in  1  info bit valid.
- o_bit_ready  out  1  encoder accepts i_bit this cycle.
- o_sym  out  MAX_N  code symbol; bit j = generator j output.
- o_sym_valid  out  1  symbol valid.
- i_sym_ready  in  1  downstream accepts symbol.
- o_sym_last  out  1  marks the final symbol of the frame.
- o_busy  out  1  frame in progress.
- o_done  out  1  one-cycle pulse at frame completion.
- o_cfg_err  out  1  one-cycle pulse when i_start arrives while busy.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs 0, including o_sym, all flags and o_bit_ready. Shift register, counters and latched config cleared.
- FSM states: IDLE, DATA, TAIL, FLUSH.
  - IDLE→DATA on i_start. Latch K, rate, polys, frame_len and tail_en; clear shift register and bit counter. o_busy=1 from the next cycle.
  - If frame_len=0 on start: go to TAIL if tail_en=1, else FLUSH directly.
  - DATA→TAIL after the frame_len-th bit is accepted, when tail_en=1. Otherwise DATA→FLUSH.
  - TAIL: generate K-1 symbols with input 0, one per free output slot. Then go to FLUSH.
  - FLUSH: wait until the last symbol is handshaked (valid&ready). Then pulse o_done, return to IDLE and drop o_busy, all in the same cycle.
  - If the frame emits no symbols (frame_len=0, tail_en=0), o_done pulses the cycle after FLUSH is entered.
- Encoding window: w[K-1]=current input, w[K-2]=previous input, …, w[0]=oldest. o_sym[j] = XOR-reduce(g_j[K-1:0] & w). Poly bits above K-1 are ignored.
  - Rate 1/2: o_sym[MAX_N-1:2]=0.
  - Shift register advances only when a symbol is produced.
- Output slot and latency:
  - Single registered output slot; slot_free = !o_sym_valid | i_sym_ready.
  - o_bit_ready = (state==DATA) & slot_free.
  - Latency: input bit accepted at edge n → its symbol is valid after edge n (registered, 1 cycle).
  - While o_sym_valid=1 and i_sym_ready=0, o_sym, o_sym_valid and o_sym_last hold stable.
  - Full throughput of 1 symbol/cycle when i_sym_ready stays high.
- o_sym_last=1 on the last info symbol (tail_en=0) or the last tail symbol (tail_en=1).
- i_start while o_busy=1: ignored, o_cfg_err pulses, the frame continues unaffected.
- i_start in the same cycle as o_done: accepted as a new frame.
- Input bits presented in IDLE, TAIL or FLUSH are not accepted (o_bit_ready=0).
- Reset mid-frame aborts immediately. No o_done; pending symbol dropped.
- Bit counter is LEN_W wide and never wraps; the compare is done against the latched frame_len.

Test Plan:
- Rate 1/2, K=3 (i_constr_len=0), g0=111, g1=101, frame_len=4, tail_en=1, bits 1,0,1,1, i_sym_ready=1 → six symbols as (o_sym[0],o_sym[1]): (1,1),(1,0),(0,0),(0,1),(0,1),(1,1). o_sym_last on the 6th; o_done one cycle after it; o_sym[2]=0 throughout.
- Same frame with i_sym_ready held low 5 cycles after the 2nd symbol → o_sym stays (1,0), o_bit_ready=0 for those cycles, then the sequence resumes unchanged with no loss or duplication.
- Rate 1/3, K=3, g=(111,101,011), frame_len=1, tail_en=0, bit 1 → single symbol (1,1,0) with o_sym_last=1, then o_done.
- frame_len=0, tail_en=0 → no o_sym_valid, o_done pulses within 2 cycles of i_start. A second i_start issued mid-frame in another run → o_cfg_err pulse, output sequence unchanged.
- K=9 (i_constr_len=3), frame_len=8, tail_en=1, random bits → 16 symbols matching the golden model, o_sym_last on the 16th.
- Assert rst=0 after the 3rd symbol → all outputs 0 asynchronously. After release, a new frame encodes from a zero shift register.
